// File: rtl/alu_operand_stage.sv
// Purpose: ID/EX register for the ALU, with EX/MEM and WB operand forwarding.
// Latency: 1 cycle from in_valid to out_valid; forwarding adds no cycles.
// Backpressure: single entry, in_ready = !out_valid | out_ready; a stalled entry is frozen except for WB refresh.
module alu_operand_stage #(
  parameter int XLEN       = 32,
  parameter int REG_ADDR_W = 5
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [REG_ADDR_W-1:0] in_rs1,
  input  logic [REG_ADDR_W-1:0] in_rs2,
  input  logic [XLEN-1:0]       in_rs1_data,
  input  logic [XLEN-1:0]       in_rs2_data,
  input  logic [XLEN-1:0]       in_imm,
  input  logic                  in_use_imm,
  input  logic [3:0]            in_alu_ctrl,
  input  logic [REG_ADDR_W-1:0] in_rd,
  input  logic                  in_rd_we,
  input  logic                  flush,
  input  logic [REG_ADDR_W-1:0] exm_rd,
  input  logic                  exm_we,
  input  logic [XLEN-1:0]       exm_data,
  input  logic [REG_ADDR_W-1:0] wb_rd,
  input  logic                  wb_we,
  input  logic [XLEN-1:0]       wb_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [XLEN-1:0]       operand1,
  output logic [XLEN-1:0]       operand2,
  output logic [3:0]            ALUControl,
  output logic [REG_ADDR_W-1:0] out_rd,
  output logic                  out_rd_we,
  output logic                  illegal_op
);

  localparam logic [3:0]            OP_MAX = 4'b0101;
  localparam logic [REG_ADDR_W-1:0] X0     = '0;

  logic                  hold_vld;
  logic [REG_ADDR_W-1:0] hold_rs1, hold_rs2, hold_rd;
  logic [XLEN-1:0]       hold_rs1_dat, hold_rs2_dat, hold_imm;
  logic                  hold_use_imm, hold_rd_we;
  logic [3:0]            hold_ctrl;

  logic                  capture, consume;
  logic                  wb_hit_in1, wb_hit_in2, wb_hit_hold1, wb_hit_hold2;
  logic [XLEN-1:0]       fwd_rs1, fwd_rs2;

  assign in_ready = !hold_vld || out_ready;
  assign capture  = in_valid && in_ready && !flush;
  assign consume  = hold_vld && out_ready;

  // A WB write to x0 never reaches the register file, so it is never a hit.
  assign wb_hit_in1   = wb_we && (wb_rd == in_rs1)   && (in_rs1   != X0);
  assign wb_hit_in2   = wb_we && (wb_rd == in_rs2)   && (in_rs2   != X0);
  assign wb_hit_hold1 = wb_we && (wb_rd == hold_rs1) && (hold_rs1 != X0);
  assign wb_hit_hold2 = wb_we && (wb_rd == hold_rs2) && (hold_rs2 != X0);

  // Operand forwarding: youngest producer (EX/MEM) wins over WB, then the held copy.
  always_comb begin
    fwd_rs1 = hold_rs1_dat;
    fwd_rs2 = hold_rs2_dat;
    if (hold_rs1 != X0) begin
      if (exm_we && (exm_rd == hold_rs1)) fwd_rs1 = exm_data;
      else if (wb_hit_hold1)              fwd_rs1 = wb_data;
    end
    if (hold_rs2 != X0) begin
      if (exm_we && (exm_rd == hold_rs2)) fwd_rs2 = exm_data;
      else if (wb_hit_hold2)              fwd_rs2 = wb_data;
    end
  end

  assign out_valid  = hold_vld;
  assign operand1   = fwd_rs1;
  assign operand2   = hold_use_imm ? hold_imm : fwd_rs2;
  assign ALUControl = hold_ctrl;
  assign out_rd     = hold_rd;
  assign out_rd_we  = hold_rd_we;
  assign illegal_op = hold_vld && (hold_ctrl > OP_MAX);

  // Pipeline register: flush beats capture; a stalled entry absorbs WB writes so the value outlives the pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_vld     <= 1'b0;
      hold_rs1     <= '0;
      hold_rs2     <= '0;
      hold_rs1_dat <= '0;
      hold_rs2_dat <= '0;
      hold_imm     <= '0;
      hold_use_imm <= 1'b0;
      hold_ctrl    <= '0;
      hold_rd      <= '0;
      hold_rd_we   <= 1'b0;
    end else if (flush) begin
      hold_vld <= 1'b0;
    end else if (capture) begin
      hold_vld     <= 1'b1;
      hold_rs1     <= in_rs1;
      hold_rs2     <= in_rs2;
      hold_rs1_dat <= wb_hit_in1 ? wb_data : in_rs1_data;
      hold_rs2_dat <= wb_hit_in2 ? wb_data : in_rs2_data;
      hold_imm     <= in_imm;
      hold_use_imm <= in_use_imm;
      hold_ctrl    <= in_alu_ctrl;
      hold_rd      <= in_rd;
      hold_rd_we   <= in_rd_we;
    end else if (consume) begin
      hold_vld <= 1'b0;
    end else if (hold_vld) begin
      if (wb_hit_hold1) hold_rs1_dat <= wb_data;
      if (wb_hit_hold2) hold_rs2_dat <= wb_data;
    end
  end

endmodule
